// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the SRAM slave FSM state set.
// Imported by the slave RTL and by the bus master side.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

endpackage

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: single-port 32-bit word RAM, asynchronous read,
// synchronous write when we is high. Contents are never reset.
//   clk   - write clock
//   we    - write enable
//   addr  - word address
//   wdata - write data
//   rdata - combinational read data at addr
module ahb_slave_mem #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic                                           clk,
    input  logic                                           we,
    input  logic [((MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1)-1:0] addr,
    input  logic [31:0]                                    wdata,
    output logic [31:0]                                    rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave backed by a word SRAM, with a
// configurable number of wait states per OKAY data phase and a two-cycle
// ERROR response for bad size, misalignment or out-of-range addresses.
//   HCLK/HRESET           - clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HBURST - address-phase inputs (HBURST ignored)
//   HWDATA                - write data in the data phase
//   HREADY                - bus ready, completes the previous data phase
//   HRDATA, HREADYOUT,
//   HRESP                 - data-phase responses
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 64,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    slave_state_e  state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic          accept;
    logic          addr_err;
    logic          load;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    slave_state_e  accept_state;

    // Burst type and the low HTRANS bit play no part in decode.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0]};

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign addr_err = (HSIZE != HSIZE_WORD) ||
                      (HADDR[1:0] != 2'b00) ||
                      ({2'b00, HADDR[31:2]} >= 32'(MEM_WORDS));

    always_comb begin
        if (addr_err) begin
            accept_state = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
            accept_state = ST_DATA;
        end else begin
            accept_state = ST_WAIT;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        mem_we    = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                load      = accept;
                state_nxt = accept ? accept_state : ST_IDLE;
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                cnt_nxt   = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // Write lands at the end of this cycle, so a pipelined read of
                // the same word in the next data phase sees it via async read.
                if (write_q) begin
                    mem_we = 1'b1;
                end else begin
                    HRDATA = mem_rdata;
                end
                load      = accept;
                state_nxt = accept ? accept_state : ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP     = HRESP_ERROR;
                load      = accept;
                state_nxt = accept ? accept_state : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (load && !addr_err) begin
            cnt_nxt = 4'(WAIT_STATES);
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                addr_q  <= HADDR[AW+1:2];
                write_q <= HWRITE;
            end
        end
    end

    ahb_slave_mem #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk  (HCLK),
        .we   (mem_we),
        .addr (addr_q),
        .wdata(HWDATA),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        use0;

    logic        sel0, sel1;
    logic [31:0] rd0, rd1;
    logic        ho0, ho1;
    logic [1:0]  rs0, rs1;
    logic        hready_bus;
    logic [31:0] hrdata;
    logic [1:0]  hresp;

    always #5 HCLK = ~HCLK;

    assign sel0       = HSEL & use0;
    assign sel1       = HSEL & ~use0;
    assign hready_bus = use0 ? ho0 : ho1;
    assign hrdata     = use0 ? rd0 : rd1;
    assign hresp      = use0 ? rs0 : rs1;

    ahb_sram_slave #(.MEM_WORDS(64), .WAIT_STATES(1)) u_dut_ws1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel1), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(hready_bus), .HRDATA(rd1),
        .HREADYOUT(ho1), .HRESP(rs1)
    );

    ahb_sram_slave #(.MEM_WORDS(64), .WAIT_STATES(0)) u_dut_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(hready_bus), .HRDATA(rd0),
        .HREADYOUT(ho0), .HRESP(rs0)
    );

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] data;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
    } stim_t;

    typedef struct {
        logic [31:0] addr;
        bit          err;
        bit          wr;
        logic [31:0] data;
        int unsigned waits;
    } exp_t;

    stim_t       stim_q[$];
    exp_t        sb_q[$];
    logic [31:0] model0 [64];
    logic [31:0] model1 [64];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned wait_cnt = 0;
    bit          mon_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
        return (sz != 3'b010) || (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    endfunction

    task automatic add(input logic [31:0] a, input bit wr, input logic [31:0] d,
                       input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz);
        stim_t s;
        s.addr = a; s.wr = wr; s.data = d; s.trans = tr; s.burst = bu; s.size = sz;
        stim_q.push_back(s);
    endtask

    // Monitor: every data-phase cycle is compared against the scoreboard head.
    always @(negedge HCLK) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                check_eq("idle_ready", 32'(hready_bus), 32'd1);
                check_eq("idle_resp", 32'(hresp), 32'd0);
            end else if (!hready_bus) begin
                wait_cnt++;
                check_eq($sformatf("wait_resp@%08h", sb_q[0].addr), 32'(hresp),
                         sb_q[0].err ? 32'd1 : 32'd0);
                check_eq($sformatf("wait_rdata@%08h", sb_q[0].addr), hrdata, 32'd0);
                if (wait_cnt > 20) begin
                    check_eq("wait_timeout", wait_cnt, sb_q[0].waits);
                    sb_q.delete(0);
                    wait_cnt = 0;
                end
            end else begin
                check_eq($sformatf("waits@%08h", sb_q[0].addr), wait_cnt, sb_q[0].waits);
                check_eq($sformatf("resp@%08h", sb_q[0].addr), 32'(hresp),
                         sb_q[0].err ? 32'd1 : 32'd0);
                check_eq($sformatf("rdata@%08h", sb_q[0].addr), hrdata,
                         (sb_q[0].err || sb_q[0].wr) ? 32'd0 : sb_q[0].data);
                sb_q.delete(0);
                wait_cnt = 0;
            end
        end
    end

    task automatic run_seq();
        stim_t       s;
        exp_t        e;
        int unsigned budget;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            HSEL = 1'b1; HADDR = s.addr; HTRANS = s.trans; HWRITE = s.wr;
            HSIZE = s.size; HBURST = s.burst;
            budget = 0;
            @(negedge HCLK);
            while (!hready_bus && budget < 20) begin
                budget++;
                @(negedge HCLK);
            end
            if (!hready_bus) check_eq("accept_timeout", 32'(hready_bus), 32'd1);
            @(posedge HCLK);
            e.addr  = s.addr;
            e.err   = exp_err(s.addr, s.size);
            e.wr    = s.wr;
            e.waits = e.err ? 1 : (use0 ? 0 : 1);
            if (!e.err && s.wr) begin
                if (use0) model0[s.addr[7:2]] = s.data;
                else      model1[s.addr[7:2]] = s.data;
            end
            e.data = e.err ? 32'd0 : (use0 ? model0[s.addr[7:2]] : model1[s.addr[7:2]]);
            sb_q.push_back(e);
            #1;
            HWDATA = s.data;
        end
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
        budget = 0;
        while (sb_q.size() > 0 && budget < 40) begin
            @(negedge HCLK);
            budget++;
        end
        if (sb_q.size() > 0) begin
            check_eq("drain_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HBURST = HBURST_SINGLE; HWDATA = '0; use0 = 1'b0;

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        check_eq("rst_ready", 32'(ho1), 32'd1);
        check_eq("rst_resp", 32'(rs1), 32'd0);
        check_eq("rst_rdata", rd1, 32'd0);
        check_eq("rst_ready_ws0", 32'(ho0), 32'd1);
        mon_en = 1'b1;

        // Single write then single read, one wait each
        add(32'h34, 1'b1, 32'h1111_1134, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();
        add(32'h34, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();

        // INCR4 pipelined writes, then pipelined readback
        for (int unsigned i = 0; i < 4; i++)
            add(32'h40 + 4 * i, 1'b1, 32'hA0 + i, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                HBURST_INCR4, HSIZE_WORD);
        run_seq();
        for (int unsigned i = 0; i < 4; i++)
            add(32'h40 + 4 * i, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();

        // BUSY and IDLE with HSEL high must not touch memory
        HSEL = 1'b1; HTRANS = HTRANS_BUSY; HWRITE = 1'b1; HADDR = 32'h34; HWDATA = 32'hBAD0_BAD0;
        repeat (2) @(posedge HCLK);
        #1;
        HTRANS = HTRANS_IDLE;
        repeat (2) @(posedge HCLK);
        #1;
        HSEL = 1'b0;

        // Error cases mixed into a pipeline; 0x34 must keep its data
        add(32'h100, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h35, 1'b1, 32'hFFFF_FFFF, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h34, 1'b1, 32'hEEEE_EEEE, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_BYTE);
        add(32'h34, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'hFC, 1'b1, 32'h0000_00FC, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'hFC, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();

        // Write directly followed by read of the same word
        add(32'h20, 1'b1, 32'h5A5A_0020, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h20, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();

        // Reset during WAIT of a write abandons it
        add(32'h10, 1'b1, 32'h1234_5678, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();
        mon_en = 1'b0;
        HSEL = 1'b1; HADDR = 32'h10; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(posedge HCLK);
        #1;
        HWDATA = 32'hDEAD_BEEF; HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        check_eq("abort_in_wait", 32'(hready_bus), 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        check_eq("abort_ready", 32'(hready_bus), 32'd1);
        check_eq("abort_resp", 32'(hresp), 32'd0);
        @(posedge HCLK);
        #1;
        mon_en = 1'b1;
        add(32'h10, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();

        // Zero-wait slave: WRAP4 beats, readback, back-to-back RAW, error
        use0 = 1'b1;
        @(posedge HCLK);
        #1;
        add(32'h38, 1'b1, 32'hB0, HTRANS_NONSEQ, HBURST_WRAP4, HSIZE_WORD);
        add(32'h3C, 1'b1, 32'hB1, HTRANS_SEQ, HBURST_WRAP4, HSIZE_WORD);
        add(32'h30, 1'b1, 32'hB2, HTRANS_SEQ, HBURST_WRAP4, HSIZE_WORD);
        add(32'h34, 1'b1, 32'hB3, HTRANS_SEQ, HBURST_WRAP4, HSIZE_WORD);
        run_seq();
        add(32'h30, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h34, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h38, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h3C, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h08, 1'b1, 32'hC0DE_0008, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h08, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h100, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h3A, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        add(32'h38, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();

        // The wait-state slave must not have seen any of that traffic
        use0 = 1'b0;
        @(posedge HCLK);
        #1;
        add(32'h34, 1'b0, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD);
        run_seq();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words of backing storage.
REQ-002 SHALL have parameter WAIT_STATES, default 1 (range 0-15), meaning the number of HREADYOUT-low cycles inserted per OKAY data phase.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESET, input, 1 bit: synchronous reset, active-low.
REQ-005 SHALL have port HSEL, input, 1 bit: slave select.
REQ-006 SHALL have port HADDR, input, 32 bits: address-phase address.
REQ-007 SHALL have port HTRANS, input, 2 bits: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-008 SHALL have ports HWRITE (input, 1 bit), HSIZE (input, 3 bits) and HBURST (input, 3 bits): transfer attributes.
REQ-009 SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-010 SHALL have port HREADY, input, 1 bit: bus-level ready; a high value completes the previous data phase.
REQ-011 SHALL have ports HRDATA (output, 32 bits), HREADYOUT (output, 1 bit) and HRESP (output, 2 bits): HRESP is OKAY 00, ERROR 01.

Function
REQ-012 An address phase SHALL be accepted only on a cycle with HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE are registered on that edge.
REQ-013 The FSM SHALL have the states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-014 An accepted transfer SHALL be an error if HSIZE!=010, HADDR[1:0]!=00, or HADDR[31:2]>=MEM_WORDS.
REQ-015 For an error transfer the FSM SHALL go to ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), then IDLE, or accept a new transfer in ERR2 if REQ-012 holds.
REQ-016 For a good transfer the FSM SHALL go to DATA if WAIT_STATES=0; otherwise it goes to WAIT with a 4-bit counter loaded with WAIT_STATES.
REQ-017 WAIT SHALL drive HREADYOUT=0 and HRESP=00 and decrement the counter each cycle, going to DATA when counter==1.
REQ-018 DATA SHALL drive HREADYOUT=1 and HRESP=00; a write stores HWDATA to mem[addr[31:2]] at the end of the DATA cycle; a read drives HRDATA=mem[addr[31:2]] during DATA.
REQ-019 HRDATA SHALL be 0 in every state other than a read DATA cycle.
REQ-020 In DATA, a transfer meeting REQ-012 SHALL be accepted on the same edge (pipelined); otherwise the FSM goes to IDLE.
REQ-021 A read whose data phase directly follows a write data phase to the same address SHALL return the newly written data.
REQ-022 IDLE and BUSY transfers, and unselected cycles, SHALL produce HREADYOUT=1 and HRESP=00, with no memory access and no state change other than to IDLE.
REQ-023 HBURST SHALL be ignored; each beat, including INCR and WRAP beats, is decoded independently from its own HADDR.
REQ-024 In IDLE, HREADYOUT SHALL be 1 and HRESP SHALL be 00.

Reset
REQ-025 When HRESET=0 at a rising edge: state=IDLE, counter=0, HREADYOUT=1, HRESP=00, HRDATA=0.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 Reset during WAIT or DATA SHALL abandon the pending transfer with no memory write.

Structure
REQ-028 The HTRANS, HRESP, HSIZE and HBURST encodings and the FSM state enumeration SHALL reside in shared package ahb_pkg, reused by the master.
REQ-029 Storage SHALL be a sub-module ahb_slave_mem: single-port word RAM with asynchronous read and synchronous write-enable, parameterised by MEM_WORDS.
REQ-030 The address decode and error check SHALL be inside ahb_sram_slave.

Verification
REQ-031 Reset -> HREADYOUT=1, HRESP=00 and HRDATA=0 on the first cycle after reset, with WAIT_STATES=1.
REQ-032 NONSEQ write of 0x11111134 to 0x34, then NONSEQ read of 0x34 -> one wait cycle each; the read data phase returns 0x11111134 with HRESP=00.
REQ-033 INCR4 write beats at 0x40, 0x44, 0x48, 0x4C with data 0xA0-0xA3, pipelined -> each beat has one wait cycle; readback of each address matches.
REQ-034 WRAP4 beats at 0x38, 0x3C, 0x30, 0x34 with WAIT_STATES=0 -> zero-wait completion; data lands at the correct wrapped addresses.
REQ-035 Read of 0x100 with MEM_WORDS=64, and a write at 0x35 -> each gets a two-cycle ERROR (HREADYOUT 0 then 1, HRESP=01); mem[0x34>>2] is unchanged.
REQ-036 HRESET asserted in WAIT of a write of 0xDEADBEEF to 0x10 -> FSM returns to IDLE and mem[4] keeps its previous value.
